// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports; data wins ties.
// Optional fetch anti-starvation counter is enabled by MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [31:0]       dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [31:0]       dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              stall_o
);

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_DM} state_t;

  state_t      state;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        force_if;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;

  assign force_if = (wait_cnt == CW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (if_gnt_o) begin
      wait_cnt <= '0;
    end else if (if_req_i && (wait_cnt != CW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants are masked during reset so nothing reaches the memory while rst is high.
  assign if_gnt_o    = ~rst & if_req_i & (~dm_req_i | force_if);
  assign dm_gnt_o    = ~rst & dm_req_i & ~if_gnt_o;
  assign stall_o     = ~rst & if_req_i & ~if_gnt_o;

  assign mem_en_o    = if_gnt_o | dm_gnt_o;
  assign mem_we_o    = dm_gnt_o & dm_we_i;
  assign mem_addr_o  = if_gnt_o ? if_addr_i : (dm_gnt_o ? dm_addr_i : '0);
  assign mem_wdata_o = dm_gnt_o ? dm_wdata_i : 32'h0;

  // A response state left over when reset arrives must not deliver data.
  assign if_rvalid_o = ~rst & (state == RESP_IF);
  assign dm_rvalid_o = ~rst & (state == RESP_DM);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : dm_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
    end else begin
      if (state == RESP_IF) if_rdata_q <= mem_rdata_i;
      if (state == RESP_DM) dm_rdata_q <= mem_rdata_i;
      if (if_gnt_o)                  state <= RESP_IF;
      else if (dm_gnt_o && !dm_we_i) state <= RESP_DM;
      else                           state <= IDLE;
    end
  end

endmodule
